// File: rtl/sample_capture_core.sv
// sample_capture_core: triggered burst capture of a sample stream into a bus-readable buffer
// Bus window at BASE_ADDR..BASE_ADDR+4: CTRL, TRIG, COUNT, RDPTR, RDDATA.
// Ports: clk, rst_n (sync, active-low); sample_i/sample_valid_i user stream;
// addr_i/data_i/rw_i/valid_i upstream bus; addr_o/data_o/rw_o/valid_o downstream bus
// (1-cycle latency, read data substituted on a window hit); capturing_o, done_o status.
// Optional SAMPLE_CAPTURE_AUTOINC_EN: each RDDATA read advances RDPTR (wrapping at DEPTH).
module sample_capture_core #(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  input  logic [15:0]      addr_i,
  input  logic [15:0]      data_i,
  input  logic             rw_i,
  input  logic             valid_i,
  output logic [15:0]      addr_o,
  output logic [15:0]      data_o,
  output logic             rw_o,
  output logic             valid_o,
  output logic             capturing_o,
  output logic             done_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] trig;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] rdptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [15:0] off, rd_val;
  logic hit, wr, rd, ctrl_wr, we;
  // Offset arithmetic wraps, so a single unsigned compare decodes the window.
  assign off = addr_i - BASE_ADDR;
  assign hit = valid_i && off < 16'd5;
  assign wr = hit && rw_i;
  assign rd = hit && !rw_i;
  assign ctrl_wr = wr && off == 16'd0;
  assign rd_val = off == 16'd0 ? 16'(state) :
                  off == 16'd1 ? 16'(trig) :
                  off == 16'd2 ? 16'(count) :
                  off == 16'd3 ? 16'(rdptr) : 16'(mem[rdptr]);
  // COUNT is always 0 in ARMED, so COUNT doubles as the write address for the trigger sample.
  always_comb begin
    state_n = state;
    count_n = count;
    we = 1'b0;
    if (ctrl_wr && data_i == 16'd1) begin
      state_n = ARMED;
      count_n = '0;
    end else if (ctrl_wr && data_i == 16'd0) begin
      state_n = IDLE;
    end else if (sample_valid_i && (state == CAPTURE || (state == ARMED && sample_i == trig))) begin
      we = 1'b1;
      count_n = count + 1'b1;
      state_n = count_n == CW'(DEPTH) ? DONE : CAPTURE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      trig <= '0;
      rdptr <= '0;
      addr_o <= '0;
      data_o <= '0;
      rw_o <= 1'b0;
      valid_o <= 1'b0;
      capturing_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      count <= count_n;
      capturing_o <= state_n == ARMED || state_n == CAPTURE;
      done_o <= state_n == DONE;
      addr_o <= addr_i;
      data_o <= rd ? rd_val : data_i;
      rw_o <= rw_i;
      valid_o <= valid_i;
      if (wr && off == 16'd1) trig <= data_i[WIDTH-1:0];
      if (wr && off == 16'd3) rdptr <= data_i[AW-1:0];
`ifdef SAMPLE_CAPTURE_AUTOINC_EN
      if (rd && off == 16'd4) rdptr <= rdptr + 1'b1;
`else
`endif
    end
  end
  // Memory is deliberately never reset; a reset edge also blocks the write.
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[count[AW-1:0]] <= sample_i;
  end
endmodule
